decode_stage: RTL and testbench

- RV32I decode stage: the producer end of the ALU operand interface.
- Accepts raw 32-bit instructions from fetch over a valid/ready handshake.
- Splits each into rd/funct3/funct7/imm, reads rs1/rs2 from an internal 32x32 register file (with a writeback port and bypass), and presents a registered operand bundle to the ALU over valid/ready.
- One output register stage, full throughput.

---
 rtl/decode_pkg.sv | 31 +++
 rtl/regfile_2r1w.sv | 40 ++++
 rtl/decode_stage.sv | 160 ++++++++++++++++
 tb/tb_decode_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, funct7 codes and the operand class enum.
// Imported by the decode stage and the ALU.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OpClassR      = 3'd0,
    OpClassImm    = 3'd1,
    OpClassLoad   = 3'd2,
    OpClassStore  = 3'd3,
    OpClassBranch = 3'd4,
    OpClassUpper  = 3'd5,
    OpClassJump   = 3'd6,
    OpClassSystem = 3'd7
  } op_class_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file with x0 hardwired to zero and write-to-read bypass.
module regfile_2r1w #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // A same-cycle writeback wins over the stale array contents.
  always_comb begin
    rdata1 = regs_q[raddr1];
    if (raddr1 == '0)                     rdata1 = '0;
    else if (wb_en && wb_rd == raddr1)    rdata1 = wb_data;
  end

  always_comb begin
    rdata2 = regs_q[raddr2];
    if (raddr2 == '0)                     rdata2 = '0;
    else if (wb_en && wb_rd == raddr2)    rdata2 = wb_data;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: splits instructions, reads operands and registers one bundle for the ALU.
// Define DECODE_M_EXT_EN to accept the MUL/DIV funct7 group as legal R-type.
module decode_stage import decode_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      op_class,
  output logic            illegal
);

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            accept;

  op_class_e       cls_d, op_class_q;
  logic            ill_d, illegal_q, valid_d, out_valid_q;
  logic [XLEN-1:0] imm_d, imm_q, rs1_d, rs1_q, rs2_d, rs2_q;
  logic [4:0]      rd_d, rd_q, rs1_idx_q, rs2_idx_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21],
                                1'b0}));

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .raddr1  (in_instr[19:15]),
    .raddr2  (in_instr[24:20]),
    .rdata1  (rdata1),
    .rdata2  (rdata2)
  );

  always_comb begin
    cls_d = OpClassR;
    imm_d = '0;
    ill_d = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE)     ill_d = 1'b0;
        else if (f7 == F7_ALT) ill_d = !(f3 == 3'b000 || f3 == 3'b101);
`ifdef DECODE_M_EXT_EN
        else if (f7 == F7_MULDIV) ill_d = 1'b0;
`endif
        else                   ill_d = 1'b1;
      end
      OPC_OP_IMM: begin
        cls_d = OpClassImm;
        imm_d = imm_i;
        if (f3 == 3'b001)      ill_d = (f7 != F7_BASE);
        else if (f3 == 3'b101) ill_d = !(f7 == F7_BASE || f7 == F7_ALT);
      end
      OPC_LOAD:   begin cls_d = OpClassLoad;   imm_d = imm_i; end
      OPC_STORE:  begin cls_d = OpClassStore;  imm_d = imm_s; end
      OPC_BRANCH: begin cls_d = OpClassBranch; imm_d = imm_b; end
      OPC_LUI, OPC_AUIPC: begin cls_d = OpClassUpper; imm_d = imm_u; end
      OPC_JAL:    begin cls_d = OpClassJump;   imm_d = imm_j; end
      OPC_JALR:   begin cls_d = OpClassJump;   imm_d = imm_i; end
      OPC_SYSTEM: begin cls_d = OpClassSystem; imm_d = imm_i; end
      default:    ill_d = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) ill_d = 1'b1;
    rd_d = (ill_d || cls_d == OpClassStore || cls_d == OpClassBranch) ? 5'd0 : in_instr[11:7];
  end

  // Held operands track writebacks so a stalled bundle never carries a stale value.
  always_comb begin
    valid_d = out_valid_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      rs1_d   = rdata1;
      rs2_d   = rdata2;
    end else begin
      if (out_ready) valid_d = 1'b0;
      if (wb_en && wb_rd != '0 && wb_rd == rs1_idx_q) rs1_d = wb_data;
      if (wb_en && wb_rd != '0 && wb_rd == rs2_idx_q) rs2_d = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rd_q        <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      op_class_q  <= OpClassR;
      illegal_q   <= 1'b0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
    end else begin
      out_valid_q <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      if (!flush && accept) begin
        rd_q       <= rd_d;
        funct3_q   <= f3;
        funct7_q   <= f7;
        imm_q      <= imm_d;
        op_class_q <= cls_d;
        illegal_q  <= ill_d;
        rs1_idx_q  <= in_instr[19:15];
        rs2_idx_q  <= in_instr[24:20];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign funct3    = funct3_q;
  assign funct7    = funct7_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign imm       = imm_q;
  assign op_class  = op_class_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with hand-computed expected bundles.
module tb_decode_stage;

  logic        clk, rst_n;
  logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready, illegal;
  logic [31:0] in_instr, wb_data, rs1, rs2, imm;
  logic [4:0]  wb_rd, rd;
  logic [2:0]  funct3, op_class;
  logic [6:0]  funct7;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  decode_stage u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .funct3    (funct3),
    .funct7    (funct7),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .op_class  (op_class),
    .illegal   (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    step();
    in_valid = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [31:0] ins, input logic [4:0] e_rd,
                     input logic [2:0] e_f3, input logic [31:0] e_imm, input logic [2:0] e_cls,
                     input logic e_ill);
    send(ins);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " rd"}, 32'(rd), 32'(e_rd));
    check({tag, " funct3"}, 32'(funct3), 32'(e_f3));
    check({tag, " imm"}, imm, e_imm);
    check({tag, " class"}, 32'(op_class), 32'(e_cls));
    check({tag, " illegal"}, 32'(illegal), 32'(e_ill));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    #12;
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst rd", 32'(rd), 32'd0);
    check("rst imm", imm, 32'd0);
    check("rst rs1", rs1, 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // ADDI x5,x0,-1
    vec("addi", 32'hFFF00293, 5'd5, 3'd0, 32'hFFFFFFFF, 3'd1, 1'b0);
    check("addi rs1", rs1, 32'd0);

    // ADD x6,x5,x5 with a same-cycle writeback of x5
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h00001234;
    send(32'h00528333);
    wb_en = 1'b0;
    check("byp rs1", rs1, 32'h00001234);
    check("byp rs2", rs2, 32'h00001234);
    check("byp rd", 32'(rd), 32'd6);
    check("byp funct7", 32'(funct7), 32'd0);
    check("byp class", 32'(op_class), 32'd0);

    // Backpressure: array read of x5, then 3 stall cycles with a writeback in the middle
    out_ready = 1'b0;
    send(32'h00528333);
    check("stall arr rs1", rs1, 32'h00001234);
    in_valid = 1'b1; in_instr = 32'hFFF00293;
    #1;
    check("stall in_ready", 32'(in_ready), 32'd0);
    step();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hAAAA0000;
    step();
    wb_en = 1'b0;
    check("stall rs1 refresh", rs1, 32'hAAAA0000);
    check("stall rs2 refresh", rs2, 32'hAAAA0000);
    step();
    check("stall rd held", 32'(rd), 32'd6);
    check("stall valid held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("b2b valid", 32'(out_valid), 32'd1);
    check("b2b rd", 32'(rd), 32'd5);
    check("b2b class", 32'(op_class), 32'd1);
    step();
    check("drain valid", 32'(out_valid), 32'd0);

    // All-zero word with a writeback aimed at x0
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    send(32'h00000000);
    wb_en = 1'b0;
    check("zero illegal", 32'(illegal), 32'd1);
    check("zero rd", 32'(rd), 32'd0);
    check("zero rs1", rs1, 32'd0);
    send(32'hFFF00293);
    check("x0 read", rs1, 32'd0);

    vec("sw", 32'hFE512E23, 5'd0, 3'd2, 32'hFFFFFFFC, 3'd3, 1'b0);
    vec("beq neg", 32'hFE000CE3, 5'd0, 3'd0, 32'hFFFFFFF8, 3'd4, 1'b0);
    vec("beq b11", 32'h000000E3, 5'd0, 3'd0, 32'h00000800, 3'd4, 1'b0);
    vec("lui", 32'hABCDE3B7, 5'd7, 3'd6, 32'hABCDE000, 3'd5, 1'b0);
    vec("auipc", 32'h00001517, 5'd10, 3'd1, 32'h00001000, 3'd5, 1'b0);
    vec("jal", 32'h003FF0EF, 5'd1, 3'd7, 32'h000FF802, 3'd6, 1'b0);
    vec("jalr", 32'h000080E7, 5'd1, 3'd0, 32'h00000000, 3'd6, 1'b0);
    vec("lw", 32'h0080A183, 5'd3, 3'd2, 32'h00000008, 3'd2, 1'b0);
    vec("ecall", 32'h00000073, 5'd0, 3'd0, 32'h00000000, 3'd7, 1'b0);
    vec("srai", 32'h4010D093, 5'd1, 3'd5, 32'h00000401, 3'd1, 1'b0);
    vec("slli alt", 32'h40109093, 5'd0, 3'd1, 32'h00000401, 3'd1, 1'b1);
    vec("sub", 32'h40000033, 5'd0, 3'd0, 32'h00000000, 3'd0, 1'b0);
    vec("slt alt", 32'h40002033, 5'd0, 3'd2, 32'h00000000, 3'd0, 1'b1);
`ifdef DECODE_M_EXT_EN
    vec("mul", 32'h023100B3, 5'd1, 3'd0, 32'h00000000, 3'd0, 1'b0);
`else
    vec("mul", 32'h023100B3, 5'd0, 3'd0, 32'h00000000, 3'd0, 1'b1);
`endif
    send(32'h00000012);
    check("lowbits illegal", 32'(illegal), 32'd1);
    check("lowbits rd", 32'(rd), 32'd0);

    // Flush with a bundle held and a new instruction offered
    out_ready = 1'b0;
    send(32'hFFF00293);
    check("pre-flush valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_instr = 32'hABCDE3B7; flush = 1'b1;
    #1;
    check("flush in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush valid", 32'(out_valid), 32'd0);
    step();
    check("flush no accept", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a stall
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h00005555;
    send(32'h00528333);
    wb_en = 1'b0;
    check("pre-rst rs1", rs1, 32'h00005555);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-rst valid", 32'(out_valid), 32'd0);
    check("mid-rst rd", 32'(rd), 32'd0);
    check("mid-rst rs1", rs1, 32'd0);
    check("mid-rst rs2", rs2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h00528333);
    check("post-rst x5", rs1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
